memory_arbiter_rr: RTL and testbench

//  Parametrised N-core RAM arbiter for multicore pipeline builds. Sits between CPUS

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/rr_pick.sv | 31 +++
 rtl/memory_arbiter_rr.sv | 141 ++++++++++++++
 tb/tb_memory_arbiter_rr.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: RAM handshake state, arbiter FSM state and the
// width helper used to size core-index fields.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // A core index needs $clog2(n) bits, but never fewer than one.
    function automatic int cpuid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first asserted request at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int N = 2,
    localparam int W = cpuid_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    logic [W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter_rr.sv
// Round-robin arbiter between CPUS cores' I/D cache ports and one single-port RAM.
// One transaction in flight; data port outranks instruction port of the same core.
module memory_arbiter_rr
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS*ADDR_W-1:0]   iaddr,
    output logic [CPUS*DATA_W-1:0]   iload,
    output logic [CPUS-1:0]          iwait,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS*ADDR_W-1:0]   daddr,
    input  logic [CPUS*DATA_W-1:0]   dstore,
    output logic [CPUS*DATA_W-1:0]   dload,
    output logic [CPUS-1:0]          dwait,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [ADDR_W-1:0]        ramaddr,
    output logic [DATA_W-1:0]        ramstore,
    input  logic [DATA_W-1:0]        ramload,
    input  ramstate_t                ramstate
);

    localparam int CW = cpuid_w(CPUS);
    typedef logic [CW-1:0] cpuid_t;

    arb_state_t  state_reg, state_next;
    cpuid_t      gnt_cpu_reg, gnt_cpu_next;
    logic        gnt_is_d_reg, gnt_is_d_next;
    cpuid_t      rr_ptr_reg, rr_ptr_next;

    logic [ADDR_W-1:0] iaddr_a  [CPUS];
    logic [ADDR_W-1:0] daddr_a  [CPUS];
    logic [DATA_W-1:0] dstore_a [CPUS];
    logic [CPUS-1:0]   dreq, anyreq;
    logic [CPUS-1:0]   sel_i, sel_d, ack_i, ack_d;
    cpuid_t            pick_idx;
    logic              pick_valid;
    logic              live;

    generate
        for (genvar gi = 0; gi < CPUS; gi++) begin : g_core
            assign iaddr_a[gi]  = iaddr[gi*ADDR_W +: ADDR_W];
            assign daddr_a[gi]  = daddr[gi*ADDR_W +: ADDR_W];
            assign dstore_a[gi] = dstore[gi*DATA_W +: DATA_W];
            assign dreq[gi]     = dREN[gi] | dWEN[gi];
            assign anyreq[gi]   = dREN[gi] | dWEN[gi] | iREN[gi];
            assign iload[gi*DATA_W +: DATA_W] = sel_i[gi] ? ramload : '0;
            assign dload[gi*DATA_W +: DATA_W] = sel_d[gi] ? ramload : '0;
            assign iwait[gi] = ~ack_i[gi];
            assign dwait[gi] = ~ack_d[gi];
        end
    endgenerate

    rr_pick #(.N(CPUS)) u_pick (
        .req       (anyreq),
        .ptr       (rr_ptr_reg),
        .gnt_idx   (pick_idx),
        .gnt_valid (pick_valid)
    );

    // The grantee still asserting the request it was granted for.
    assign live = gnt_is_d_reg ? dreq[gnt_cpu_reg] : iREN[gnt_cpu_reg];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg    <= ARB_IDLE;
            gnt_cpu_reg  <= '0;
            gnt_is_d_reg <= 1'b0;
            rr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_cpu_reg  <= gnt_cpu_next;
            gnt_is_d_reg <= gnt_is_d_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_cpu_next  = gnt_cpu_reg;
        gnt_is_d_next = gnt_is_d_reg;
        rr_ptr_next   = rr_ptr_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next    = ARB_BUSY;
                    gnt_cpu_next  = pick_idx;
                    gnt_is_d_next = dreq[pick_idx];
                end
            end
            ARB_BUSY: begin
                // An abort leaves the pointer alone so the same core keeps its turn.
                if (!live) begin
                    state_next = ARB_IDLE;
                end else if (ramstate == ACCESS) begin
                    state_next  = ARB_IDLE;
                    rr_ptr_next = (gnt_cpu_reg == cpuid_t'(CPUS - 1)) ? '0 : gnt_cpu_reg + 1'b1;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        sel_i    = '0;
        sel_d    = '0;
        ack_i    = '0;
        ack_d    = '0;
        if (state_reg == ARB_BUSY) begin
            if (gnt_is_d_reg) sel_d[gnt_cpu_reg] = 1'b1;
            else              sel_i[gnt_cpu_reg] = 1'b1;
            if (live) begin
                if (gnt_is_d_reg) begin
                    ramaddr  = daddr_a[gnt_cpu_reg];
                    ramWEN   = dWEN[gnt_cpu_reg];
                    ramREN   = dREN[gnt_cpu_reg] & ~dWEN[gnt_cpu_reg];
                    ramstore = dWEN[gnt_cpu_reg] ? dstore_a[gnt_cpu_reg] : '0;
                end else begin
                    ramaddr = iaddr_a[gnt_cpu_reg];
                    ramREN  = 1'b1;
                end
                if (ramstate == ACCESS) begin
                    if (gnt_is_d_reg) ack_d[gnt_cpu_reg] = 1'b1;
                    else              ack_i[gnt_cpu_reg] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Directed bench for the two-core round-robin RAM arbiter.
module tb_memory_arbiter_rr;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [CPUS-1:0]   iREN, iwait, dREN, dWEN, dwait;
    logic [CPUS*AW-1:0] iaddr, daddr;
    logic [CPUS*DW-1:0] iload, dstore, dload;
    logic              ramREN, ramWEN;
    logic [AW-1:0]     ramaddr;
    logic [DW-1:0]     ramstore, ramload;
    ramstate_t         ramstate;

    int checks   = 0;
    int failures = 0;

    memory_arbiter_rr #(.CPUS(CPUS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        cyc(); cyc();
        nRST = 1'b1;
        cyc();
        dREN = 2'b01; daddr = {32'h0000_0200, 32'h0000_0100};
        cyc();                              // now BUSY, grant core 0
        ramstate = ACCESS;
        #1;
        checks++;
        if (dwait !== 2'b10) begin failures++; $display("FAIL reset_pre_busy dwait got=%b exp=10", dwait); end
        nRST = 1'b0;
        #1;
        checks++;
        if (iwait !== 2'b11 || dwait !== 2'b11) begin
            failures++; $display("FAIL reset_waits iwait=%b dwait=%b exp=11/11", iwait, dwait);
        end
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== '0 || ramstore !== '0) begin
            failures++; $display("FAIL reset_ram ren=%b wen=%b addr=%h store=%h exp all 0", ramREN, ramWEN, ramaddr, ramstore);
        end
        checks++;
        if (iload !== '0 || dload !== '0) begin
            failures++; $display("FAIL reset_loads iload=%h dload=%h exp 0", iload, dload);
        end
        $display("txn reset asserted mid-transaction");
        dREN = 2'b11;
        cyc();
        nRST = 1'b1;
        cyc();                              // first grant after release
        checks++;
        if (dwait !== 2'b10 || ramaddr !== 32'h0000_0100) begin
            failures++; $display("FAIL reset_first_grant dwait=%b addr=%h exp=10/00000100", dwait, ramaddr);
        end
        cyc();                              // back to IDLE, rr_ptr=1
        clear_inputs();
        cyc();
        $display("txn reset first grant core0");
    endtask

    task automatic test_single_read();
        iREN = 2'b01; iaddr = {32'h0, 32'h0000_0040}; ramload = 32'hDEAD_BEEF; ramstate = FREE;
        cyc();                              // grant
        checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || iwait !== 2'b11) begin
            failures++; $display("FAIL iread_grant ren=%b wen=%b addr=%h iwait=%b exp 1/0/40/11", ramREN, ramWEN, ramaddr, iwait);
        end
        cyc();
        checks++;
        if (iwait !== 2'b11) begin failures++; $display("FAIL iread_wait1 iwait=%b exp=11", iwait); end
        cyc();
        ramstate = ACCESS;
        #1;
        checks++;
        if (iwait !== 2'b10 || iload !== {32'h0, 32'hDEAD_BEEF} || dload !== '0) begin
            failures++; $display("FAIL iread_done iwait=%b iload=%h dload=%h exp 10/0000000deadbeef/0", iwait, iload, dload);
        end
        cyc();
        checks++;
        if (iwait !== 2'b11 || ramREN !== 1'b0 || iload !== '0) begin
            failures++; $display("FAIL iread_single_pulse iwait=%b ren=%b iload=%h exp 11/0/0", iwait, ramREN, iload);
        end
        clear_inputs();
        cyc();
        $display("txn iread core0 addr=40 data=deadbeef");
    endtask

    task automatic test_fairness();
        logic [0:0] exp_core;
        logic [1:0] exp_dwait;
        dREN = 2'b11; daddr = {32'h0000_0200, 32'h0000_0100}; ramstate = ACCESS;
        exp_core = 1'b1;                    // rr_ptr is 1 after the I read on core 0
        for (int t = 0; t < 4; t++) begin
            cyc();
            exp_dwait = (exp_core == 1'b1) ? 2'b01 : 2'b10;
            checks++;
            if (dwait !== exp_dwait || ramaddr !== ((exp_core == 1'b1) ? 32'h200 : 32'h100)) begin
                failures++; $display("FAIL fair_grant%0d dwait=%b addr=%h exp_core=%0d", t, dwait, ramaddr, exp_core);
            end
            $display("txn fair grant %0d core=%0d", t, exp_core);
            cyc();
            checks++;
            if (dwait !== 2'b11) begin failures++; $display("FAIL fair_idle%0d dwait=%b exp=11", t, dwait); end
            exp_core = ~exp_core;
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_d_over_i();
        iREN = 2'b10; dWEN = 2'b10;
        iaddr = {32'h0000_0080, 32'h0}; daddr = {32'h0000_0300, 32'h0};
        dstore = {32'h0000_1234, 32'h0}; ramstate = FREE;
        cyc();
        checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234 || ramaddr !== 32'h300) begin
            failures++; $display("FAIL dovi_write wen=%b ren=%b store=%h addr=%h exp 1/0/1234/300", ramWEN, ramREN, ramstore, ramaddr);
        end
        ramstate = ACCESS;
        #1;
        checks++;
        if (dwait !== 2'b01 || iwait !== 2'b11) begin
            failures++; $display("FAIL dovi_write_ack dwait=%b iwait=%b exp 01/11", dwait, iwait);
        end
        $display("txn write core1 addr=300 data=1234");
        cyc();
        dWEN = 2'b00;
        cyc();                              // I request granted on its own round
        checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h80 || iwait !== 2'b01) begin
            failures++; $display("FAIL dovi_iread ren=%b wen=%b addr=%h iwait=%b exp 1/0/80/01", ramREN, ramWEN, ramaddr, iwait);
        end
        $display("txn iread core1 addr=80");
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_abort();
        dREN = 2'b01; daddr = {32'h0000_0600, 32'h0000_0500}; ramstate = BUSY;
        cyc();
        cyc();
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h500 || dwait !== 2'b11) begin
            failures++; $display("FAIL abort_busy ren=%b addr=%h dwait=%b exp 1/500/11", ramREN, ramaddr, dwait);
        end
        dREN = 2'b00;
        #1;
        checks++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 2'b11) begin
            failures++; $display("FAIL abort_drop ren=%b wen=%b dwait=%b exp 0/0/11", ramREN, ramWEN, dwait);
        end
        cyc();
        checks++;
        if (ramREN !== 1'b0 || dwait !== 2'b11) begin
            failures++; $display("FAIL abort_idle ren=%b dwait=%b exp 0/11", ramREN, dwait);
        end
        // Pointer must still favour core 0.
        dREN = 2'b11; ramstate = ACCESS;
        cyc();
        checks++;
        if (dwait !== 2'b10 || ramaddr !== 32'h500) begin
            failures++; $display("FAIL abort_rr_kept dwait=%b addr=%h exp 10/500", dwait, ramaddr);
        end
        $display("txn abort core0 then regrant core0");
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_error();
        int acks;
        acks = 0;
        dREN = 2'b10; daddr = {32'h0000_0600, 32'h0}; ramload = 32'hCAFE_0001; ramstate = ERROR;
        cyc();
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (dwait !== 2'b11 || ramREN !== 1'b1 || ramaddr !== 32'h600) begin
                failures++; $display("FAIL error_hold%0d dwait=%b ren=%b addr=%h exp 11/1/600", t, dwait, ramREN, ramaddr);
            end
            if (t < 2) cyc();
        end
        ramstate = ACCESS;
        #1;
        if (dwait[1] === 1'b0) acks++;
        checks++;
        if (dwait !== 2'b01 || dload !== {32'hCAFE_0001, 32'h0}) begin
            failures++; $display("FAIL error_complete dwait=%b dload=%h exp 01/cafe000100000000", dwait, dload);
        end
        cyc();
        if (dwait[1] === 1'b0) acks++;
        checks++;
        if (acks != 1) begin failures++; $display("FAIL error_single_ack acks=%0d exp=1", acks); end
        $display("txn error x3 then access core1");
        clear_inputs();
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_d_over_i();
        test_abort();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
